// File: rtl/main_ctrl_fsm.sv
// STRELA CGRA run sequencer: optional configuration reload, then a kernel run gated
// on every active memory node reporting done. The loaded configuration is cached.
package main_ctrl_fsm_pkg;
  typedef enum logic [1:0] {
    S_MAIN_IDLE = 2'd0,
    S_MAIN_WAIT = 2'd1,
    S_MAIN_EXEC = 2'd2
  } main_fsm_t;
endpackage

module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
#(
  parameter int INPUT_NODES  = 4,
  parameter int OUTPUT_NODES = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               clr_conf_i,
  input  logic [31:0]                        conf_addr_i,
  input  logic [15:0]                        conf_size_i,
  input  logic [INPUT_NODES-1:0][15:0]       imn_size_i,
  input  logic [OUTPUT_NODES-1:0][15:0]      omn_size_i,
  output logic                               conf_start_o,
  input  logic                               conf_loaded_i,
  output logic                               exec_start_o,
  input  logic [INPUT_NODES-1:0]             imn_done_i,
  input  logic [OUTPUT_NODES-1:0]            omn_done_i,
  output main_fsm_t                          state_o,
  output logic                               conf_done_o,
  output logic                               exec_done_o,
  output logic                               busy_o
);

  main_fsm_t                r_state, w_state_nxt;
  logic                     r_conf_valid, r_clr_pending;
  logic [31:0]              r_conf_addr;
  logic [15:0]              r_conf_size;
  logic [INPUT_NODES-1:0]   r_imn_act, r_imn_seen, w_imn_act_new;
  logic [OUTPUT_NODES-1:0]  r_omn_act, r_omn_seen, w_omn_act_new;
  logic                     r_conf_start, r_exec_start, r_conf_done, r_exec_done, r_busy;
  logic                     w_conf_start, w_exec_start, w_conf_done, w_exec_done;
  logic                     w_hit, w_load_ok, w_cov, w_accept;

  always_comb begin
    w_imn_act_new = '0;
    w_omn_act_new = '0;
    for (int k = 0; k < INPUT_NODES; k++)  w_imn_act_new[k] = (imn_size_i[k] != 16'd0);
    for (int k = 0; k < OUTPUT_NODES; k++) w_omn_act_new[k] = (omn_size_i[k] != 16'd0);
  end

  // A coincident clear wins over the cache, forcing the reload path.
  assign w_hit = (conf_size_i == 16'd0) ||
                 (r_conf_valid && !clr_conf_i &&
                  r_conf_addr == conf_addr_i && r_conf_size == conf_size_i);
  assign w_accept = (r_state == S_MAIN_IDLE) && start_i;
  // The first WAIT cycle is the one carrying conf_start_o; a loaded pulse there is stale.
  assign w_load_ok = (r_state == S_MAIN_WAIT) && conf_loaded_i && !r_conf_start;
  assign w_cov = (&(r_imn_seen | imn_done_i | ~r_imn_act)) &&
                 (&(r_omn_seen | omn_done_i | ~r_omn_act));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_MAIN_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_MAIN_IDLE: if (start_i) w_state_nxt = w_hit ? S_MAIN_EXEC : S_MAIN_WAIT;
      S_MAIN_WAIT: if (w_load_ok) w_state_nxt = S_MAIN_EXEC;
      S_MAIN_EXEC: if (w_cov) w_state_nxt = S_MAIN_IDLE;
      default:     w_state_nxt = S_MAIN_IDLE;
    endcase
  end

  always_comb begin
    w_conf_start = w_accept && !w_hit;
    w_exec_start = (w_accept && w_hit) || w_load_ok;
    w_conf_done  = w_exec_start;
    w_exec_done  = (r_state == S_MAIN_EXEC) && w_cov;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conf_start <= 1'b0;
      r_exec_start <= 1'b0;
      r_conf_done  <= 1'b0;
      r_exec_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_conf_start <= w_conf_start;
      r_exec_start <= w_exec_start;
      r_conf_done  <= w_conf_done;
      r_exec_done  <= w_exec_done;
      r_busy       <= (w_state_nxt != S_MAIN_IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conf_valid  <= 1'b0;
      r_clr_pending <= 1'b0;
      r_conf_addr   <= '0;
      r_conf_size   <= '0;
      r_imn_act     <= '0;
      r_omn_act     <= '0;
      r_imn_seen    <= '0;
      r_omn_seen    <= '0;
    end else begin
      case (r_state)
        S_MAIN_IDLE: begin
          if (start_i) begin
            r_imn_act  <= w_imn_act_new;
            r_omn_act  <= w_omn_act_new;
            r_imn_seen <= '0;
            r_omn_seen <= '0;
          end
          if (start_i && !w_hit) begin
            r_conf_addr  <= conf_addr_i;
            r_conf_size  <= conf_size_i;
            r_conf_valid <= 1'b0;
          end else if (clr_conf_i) begin
            r_conf_valid <= 1'b0;
          end
        end
        S_MAIN_WAIT: begin
          if (w_load_ok) begin
            r_conf_valid  <= !(r_clr_pending || clr_conf_i);
            r_clr_pending <= 1'b0;
          end else if (clr_conf_i) begin
            r_clr_pending <= 1'b1;
          end
        end
        S_MAIN_EXEC: begin
          r_imn_seen <= r_imn_seen | (imn_done_i & r_imn_act);
          r_omn_seen <= r_omn_seen | (omn_done_i & r_omn_act);
          if (clr_conf_i) r_conf_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign state_o      = r_state;
  assign conf_start_o = r_conf_start;
  assign exec_start_o = r_exec_start;
  assign conf_done_o  = r_conf_done;
  assign exec_done_o  = r_exec_done;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Bench for main_ctrl_fsm: table of runs, hand corner sequences, then random runs
// predicted by a run-level model of the configuration cache.
module tb_main_ctrl_fsm;
  import main_ctrl_fsm_pkg::*;

  logic             clk_i = 1'b0, rst_ni = 1'b0;
  logic             start_i = 1'b0, clr_conf_i = 1'b0, conf_loaded_i = 1'b0;
  logic [31:0]      conf_addr_i = '0;
  logic [15:0]      conf_size_i = '0;
  logic [3:0][15:0] imn_size_i = '0, omn_size_i = '0;
  logic [3:0]       imn_done_i = '0, omn_done_i = '0;
  logic             conf_start_o, exec_start_o, conf_done_o, exec_done_o, busy_o;
  main_fsm_t        state_o;

  int errors = 0, checks = 0;

  // run-level model of the configuration cache
  bit          m_valid = 0;
  logic [31:0] m_addr  = '0;
  logic [15:0] m_size  = '0;

  main_ctrl_fsm #(.INPUT_NODES(4), .OUTPUT_NODES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clr_conf_i(clr_conf_i),
    .conf_addr_i(conf_addr_i), .conf_size_i(conf_size_i),
    .imn_size_i(imn_size_i), .omn_size_i(omn_size_i),
    .conf_start_o(conf_start_o), .conf_loaded_i(conf_loaded_i),
    .exec_start_o(exec_start_o), .imn_done_i(imn_done_i), .omn_done_i(omn_done_i),
    .state_o(state_o), .conf_done_o(conf_done_o), .exec_done_o(exec_done_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // compares {state, conf_start, exec_start, conf_done, exec_done, busy}
  task automatic chk_out(input string nm, input logic [1:0] st, input bit cs, es, cd, ed);
    logic [6:0] act, exp;
    act = {state_o, conf_start_o, exec_start_o, conf_done_o, exec_done_o, busy_o};
    exp = {st, cs, es, cd, ed, (st != 2'd0)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {st,cs,es,cd,ed,busy}=%b want %b", nm, $time, act, exp);
    end
  endtask

  // One complete run. lat >= 1: WAIT cycle index at which conf_loaded_i is accepted.
  // dfi/dfo >= 0 fix node-0 done offsets within EXEC; otherwise offsets are random.
  task automatic do_run(input logic [31:0] a, input logic [15:0] cs, input logic [3:0] im, om,
                        input bit clr_s, clr_w, clr_e, exp_rl, input int lat,
                        input bit stray, junk, input int dfi, dfo);
    int d_i[4], d_o[4];
    int last;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      d_i[k] = $urandom_range(0, 5);
      d_o[k] = $urandom_range(0, 5);
    end
    if (dfi >= 0) d_i[0] = dfi;
    if (dfo >= 0) d_o[0] = dfo;
    for (int k = 0; k < 4; k++) begin
      if (im[k] && d_i[k] > last) last = d_i[k];
      if (om[k] && d_o[k] > last) last = d_o[k];
      imn_size_i[k] = im[k] ? 16'($urandom_range(1, 500)) : 16'd0;
      omn_size_i[k] = om[k] ? 16'($urandom_range(1, 500)) : 16'd0;
    end
    conf_addr_i = a; conf_size_i = cs;
    start_i = 1'b1; clr_conf_i = clr_s;
    tick();
    start_i = 1'b0; clr_conf_i = 1'b0;
    // parameters must only matter on the accepted start cycle
    conf_addr_i = $urandom; conf_size_i = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      imn_size_i[k] = 16'($urandom);
      omn_size_i[k] = 16'($urandom);
    end
    if (exp_rl) begin
      for (int c = 0; c <= lat; c++) begin
        chk_out("wait", 2'd1, c == 0, 1'b0, 1'b0, 1'b0);
        conf_loaded_i = (c == lat) || (stray && c == 0);
        clr_conf_i    = clr_w && c == 0;
        start_i       = junk;
        tick();
        conf_loaded_i = 1'b0; clr_conf_i = 1'b0; start_i = 1'b0;
      end
      m_valid = !clr_w; m_addr = a; m_size = cs;
    end else if (clr_s) begin
      m_valid = 0;
    end
    for (int c = 0; c <= last; c++) begin
      chk_out("exec", 2'd2, 1'b0, c == 0, c == 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        imn_done_i[k] = im[k] ? (d_i[k] == c) : (junk && $urandom_range(0, 1) == 1);
        omn_done_i[k] = om[k] ? (d_o[k] == c) : (junk && $urandom_range(0, 1) == 1);
      end
      start_i    = junk;
      clr_conf_i = clr_e && c == 0;
      tick();
      imn_done_i = '0; omn_done_i = '0; start_i = 1'b0; clr_conf_i = 1'b0;
    end
    if (clr_e) m_valid = 0;
    chk_out("exec_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [15:0] csize;
    logic [3:0]  im, om;
    bit          clr_s, clr_w, clr_e, exp_rl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h2000, 16'd8, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1}; // clear during WAIT
    tbl[1] = '{32'h2000, 16'd8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1}; // so this reloads
    tbl[2] = '{32'h2000, 16'd8, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0}; // cache hit
    tbl[3] = '{32'h2000, 16'd8, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1}; // clear with start
    tbl[4] = '{32'h2000, 16'd8, 4'hf, 4'hf, 1'b0, 1'b0, 1'b1, 1'b0}; // hit, clear in EXEC
    tbl[5] = '{32'h2000, 16'd8, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}; // reload after it
    tbl[6] = '{32'h3000, 16'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // all zero: 1-cycle EXEC
    tbl[7] = '{32'h2000, 16'd8, 4'h5, 4'ha, 1'b0, 1'b0, 1'b0, 1'b0}; // cache kept
    tbl[8] = '{32'h2000, 16'd9, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1}; // size differs

    tick(); tick();
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();
    chk_out("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // loader answers 5 cycles after conf_start_o; imn0 and omn0 done at different cycles
    do_run(32'h1000, 16'd8, 4'h1, 4'h1, 0, 0, 0, 1, 5, 0, 0, 1, 3);
    do_run(32'h1000, 16'd8, 4'h1, 4'h1, 0, 0, 0, 0, 1, 0, 0, 4, 2);
    // stale loaded pulse, starts during WAIT/EXEC and done on unmasked nodes
    do_run(32'h1800, 16'd4, 4'h1, 4'h1, 0, 0, 0, 1, 3, 1, 1, 5, 4);

    foreach (tbl[i])
      do_run(tbl[i].addr, tbl[i].csize, tbl[i].im, tbl[i].om, tbl[i].clr_s, tbl[i].clr_w,
             tbl[i].clr_e, tbl[i].exp_rl, $urandom_range(1, 4), 1'b0, 1'b1, -1, -1);

    // reset in the middle of EXEC
    conf_addr_i = 32'h4000; conf_size_i = 16'd8;
    imn_size_i = '0; omn_size_i = '0; imn_size_i[0] = 16'd4;
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk_out("rst_wait", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    conf_loaded_i = 1'b1; tick(); conf_loaded_i = 1'b0;
    chk_out("rst_exec", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_ni = 1'b0; #1;
    chk_out("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_ni = 1'b1; m_valid = 0;
    tick();
    chk_out("after_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_run(32'h4000, 16'd8, 4'h1, 4'h0, 0, 0, 0, 1, 2, 0, 0, -1, -1);

    for (int r = 0; r < 40; r++) begin
      logic [31:0] a;
      logic [15:0] cs;
      bit cls, clw, cle, rl;
      a   = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
      cs  = ($urandom_range(0, 3) == 0) ? 16'd0 : (($urandom_range(0, 2) == 0) ? 16'd4 : 16'd8);
      cls = ($urandom_range(0, 7) == 0);
      clw = ($urandom_range(0, 5) == 0);
      cle = ($urandom_range(0, 7) == 0);
      rl  = (cs != 0) && !(m_valid && !cls && m_addr == a && m_size == cs);
      do_run(a, cs, 4'($urandom), 4'($urandom), cls, clw, cle, rl,
             $urandom_range(1, 6), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
